// File: rtl/sampler_pkg.sv
// Shared types and constants for the constraint sample scheduler.
// The optional SAMPLER_DEDUP_EN feature is implemented in the top module.
package sampler_pkg;

   localparam int CHUNK_W = 64;
   localparam logic [63:0] XS_ZERO_SEED = 64'h9E3779B97F4A7C15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_EVAL,
      S_HOLD,
      S_FIN
   } smp_state_e;

   function automatic int nchunk(input int w);
      return (w + CHUNK_W - 1) / CHUNK_W;
   endfunction

endpackage

// File: rtl/sampler_xorshift64.sv
// xorshift64 generator; word is the value the state takes on the next step.
module sampler_xorshift64
   import sampler_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [CHUNK_W-1:0] seed,
   input  logic               step,
   output logic [CHUNK_W-1:0] word
);

   logic [CHUNK_W-1:0] state;
   logic [CHUNK_W-1:0] s1;
   logic [CHUNK_W-1:0] s2;

   always_comb begin
      s1   = state ^ (state << 13);
      s2   = s1 ^ (s1 >> 7);
      word = s2 ^ (s2 << 17);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= '0;
      end else if (load) begin
         state <= seed;
      end else if (step) begin
         state <= word;
      end
   end

endmodule

// File: rtl/constraint_sample_scheduler.sv
// Drives a combinational constraint checker with xorshift64 candidates.
// Define SAMPLER_DEDUP_EN to drop repeats of the last emitted sample.
module constraint_sample_scheduler
   import sampler_pkg::*;
#(
   parameter int VEC_W = 506
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [63:0]      seed,
   input  logic [15:0]      num_samples,
   input  logic [31:0]      max_attempts,
   output logic [VEC_W-1:0] cand,
   input  logic             sat,
   output logic [VEC_W-1:0] smp_data,
   output logic             smp_valid,
   input  logic             smp_ready,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [31:0]      attempts,
   output logic [15:0]      accepted
);

   localparam int NCHUNK = nchunk(VEC_W);
   localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   smp_state_e state;
   smp_state_e state_n;

   logic [KW-1:0]      k;
   logic [CHUNK_W-1:0] word;
   logic [CHUNK_W-1:0] seed_eff;
   logic load;
   logic step;
   logic clr;
   logic capture;
   logic inc_att;
   logic inc_acc;
   logic set_to;
   logic dup;
   logic last_att;
   logic budget_out;

   assign seed_eff = (seed == '0) ? XS_ZERO_SEED : seed;

   sampler_xorshift64 u_rng (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .seed (seed_eff),
      .step (step),
      .word (word)
   );

   assign smp_valid = (state == S_HOLD);
   assign done      = (state == S_FIN);
   assign busy      = (state != S_IDLE);

   assign last_att   = (max_attempts != '0) &&
                       (attempts + 32'd1 == max_attempts);
   assign budget_out = (max_attempts != '0) &&
                       (attempts == max_attempts);

`ifdef SAMPLER_DEDUP_EN
   logic [VEC_W-1:0] hist;
   logic             hist_vld;

   assign dup = hist_vld && (cand == hist);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         hist     <= '0;
         hist_vld <= 1'b0;
      end else if (capture) begin
         hist     <= cand;
         hist_vld <= 1'b1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      clr     = 1'b0;
      capture = 1'b0;
      inc_att = 1'b0;
      inc_acc = 1'b0;
      set_to  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               load = 1'b1;
               clr  = 1'b1;
               if (num_samples == '0) begin
                  state_n = S_FIN;
               end else begin
                  state_n = S_FILL;
               end
            end
         end
         S_FILL: begin
            step = 1'b1;
            if (k == K_LAST) begin
               state_n = S_EVAL;
            end
         end
         S_EVAL: begin
            inc_att = 1'b1;
            if (sat && !dup) begin
               capture = 1'b1;
               state_n = S_HOLD;
            end else if (last_att) begin
               set_to  = 1'b1;
               state_n = S_FIN;
            end else begin
               state_n = S_FILL;
            end
         end
         S_HOLD: begin
            if (smp_ready) begin
               inc_acc = 1'b1;
               if (accepted + 16'd1 == num_samples) begin
                  state_n = S_FIN;
               end else if (budget_out) begin
                  set_to  = 1'b1;
                  state_n = S_FIN;
               end else begin
                  state_n = S_FILL;
               end
            end
         end
         S_FIN: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k        <= '0;
         smp_data <= '0;
         attempts <= '0;
         accepted <= '0;
         timeout  <= 1'b0;
      end else begin
         if (clr) begin
            k        <= '0;
            attempts <= '0;
            accepted <= '0;
            timeout  <= 1'b0;
         end
         if (step) begin
            k <= (k == K_LAST) ? '0 : k + KW'(1);
         end
         if (inc_att) begin
            attempts <= attempts + 32'd1;
         end
         if (inc_acc) begin
            accepted <= accepted + 16'd1;
         end
         if (set_to) begin
            timeout <= 1'b1;
         end
         if (capture) begin
            smp_data <= cand;
         end
      end
   end

   // Last chunk keeps only the bits that fit below VEC_W.
   for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
      localparam int LO = c * CHUNK_W;
      localparam int HI = (LO + CHUNK_W > VEC_W) ?
                          VEC_W - 1 : LO + CHUNK_W - 1;
      logic [HI-LO:0] q;

      always_ff @(posedge clk) begin
         if (rst) begin
            q <= '0;
         end else if (step && (k == KW'(c))) begin
            q <= word[HI-LO:0];
         end
      end

      assign cand[HI:LO] = q;
   end

endmodule
